// File: rtl/eth_mdc_clkgen.sv
// MDC clock generator: divides Clk by a clamped Divider and emits MdcEn/MdcEn_n strobes.
// Build option: define ETH_CLKGEN_ODD_DIV_EN to honour odd dividers (Lo = Hi+1); otherwise D is forced even.
module eth_mdc_clkgen #(
  parameter int DIV_W   = 8,
  parameter int MIN_DIV = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [DIV_W-1:0] Divider,
  input  logic             Run,
  output logic             Mdc,
  output logic             MdcEn,
  output logic             MdcEn_n,
  output logic             Active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             mdc_q;

  logic [DIV_W-1:0] div_clamp_d;
  logic [DIV_W-1:0] div_eff_d;
  logic [DIV_W-1:0] hi_new_d;
  logic [DIV_W-1:0] lo_cur_d;
  logic             cnt_zero_d;
  logic             mdc_en_d;

  always_comb begin
    div_clamp_d = (Divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : Divider;
`ifdef ETH_CLKGEN_ODD_DIV_EN
    div_eff_d = div_clamp_d;
`else
    div_eff_d = {div_clamp_d[DIV_W-1:1], 1'b0};
`endif
    hi_new_d   = div_eff_d >> 1;
    // Low phase always uses the divider latched at the start of this period.
    lo_cur_d   = div_q - (div_q >> 1);
    cnt_zero_d = (cnt_q == '0);
    // Reset gates the Run path so both strobes read 0 while Reset is held.
    mdc_en_d   = Run & ~Reset & cnt_zero_d & ((state_q == IDLE) | (state_q == LOW));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(MIN_DIV);
      mdc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mdc_q <= 1'b0;
          cnt_q <= '0;
          if (Run) begin
            state_q <= HIGH;
            div_q   <= div_eff_d;
            cnt_q   <= hi_new_d - DIV_W'(1);
            mdc_q   <= 1'b1;
          end
        end
        HIGH: begin
          if (!cnt_zero_d) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else begin
            state_q <= LOW;
            mdc_q   <= 1'b0;
            cnt_q   <= lo_cur_d - DIV_W'(1);
          end
        end
        LOW: begin
          if (!cnt_zero_d) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else if (Run) begin
            state_q <= HIGH;
            div_q   <= div_eff_d;
            cnt_q   <= hi_new_d - DIV_W'(1);
            mdc_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            mdc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          mdc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Mdc     = mdc_q;
  assign MdcEn   = mdc_en_d;
  assign MdcEn_n = (state_q == HIGH) & cnt_zero_d;
  assign Active  = (state_q != IDLE);

endmodule

// File: tb/tb_eth_mdc_clkgen.sv
// Directed bench for eth_mdc_clkgen; per-cycle checks of {Mdc, MdcEn, MdcEn_n, Active}.
module tb_eth_mdc_clkgen;

  logic       Clk;
  logic       Reset;
  logic [7:0] Divider;
  logic       Run;
  logic       Mdc;
  logic       MdcEn;
  logic       MdcEn_n;
  logic       Active;

  int n_chk = 0;
  int n_err = 0;

  eth_mdc_clkgen #(.DIV_W(8), .MIN_DIV(2)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Divider(Divider),
    .Run    (Run),
    .Mdc    (Mdc),
    .MdcEn  (MdcEn),
    .MdcEn_n(MdcEn_n),
    .Active (Active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs {Mdc,MdcEn,MdcEn_n,Active}, then advance one cycle.
  task automatic cyc(input string tag, input logic [3:0] exp);
    #1;
    check(tag, {28'b0, Mdc, MdcEn, MdcEn_n, Active}, {28'b0, exp});
    @(negedge Clk);
  endtask

  // One Mdc period starting at its MdcEn cycle; ends positioned on the last low cycle.
  task automatic period(input string tag, input int hi, input int lo, input logic act0,
                        input int sw_at, input logic [7:0] sw_val);
    cyc(tag, {1'b0, 1'b1, 1'b0, act0});
    for (int i = 0; i < hi; i++) begin
      if (i == sw_at) Divider = sw_val;
      cyc(tag, {1'b1, 1'b0, (i == hi - 1), 1'b1});
    end
    for (int i = 0; i < lo - 1; i++) cyc(tag, 4'b0001);
  endtask

  initial begin
    Reset   = 1'b1;
    Run     = 1'b0;
    Divider = 8'd8;
    repeat (2) @(negedge Clk);
    cyc("rst_idle", 4'b0000);
    Run = 1'b1;
    cyc("rst_run_held", 4'b0000);

    Reset = 1'b0;
    period("div8_p0", 4, 4, 1'b0, -1, 8'd0);
    period("div8_p1", 4, 4, 1'b1, -1, 8'd0);
    period("div8_p2", 4, 4, 1'b1, -1, 8'd0);

    Divider = 8'd0;
    period("div0_a", 1, 1, 1'b1, -1, 8'd0);
    period("div0_b", 1, 1, 1'b1, -1, 8'd0);
    Divider = 8'd1;
    period("div1_a", 1, 1, 1'b1, -1, 8'd0);
    period("div1_b", 1, 1, 1'b1, -1, 8'd0);
    Divider = 8'd2;
    period("div2_a", 1, 1, 1'b1, -1, 8'd0);
    period("div2_b", 1, 1, 1'b1, -1, 8'd0);

    Divider = 8'd5;
`ifdef ETH_CLKGEN_ODD_DIV_EN
    period("div5_odd_a", 2, 3, 1'b1, -1, 8'd0);
    period("div5_odd_b", 2, 3, 1'b1, -1, 8'd0);
`else
    period("div5_even_a", 2, 2, 1'b1, -1, 8'd0);
    period("div5_even_b", 2, 2, 1'b1, -1, 8'd0);
`endif

    Divider = 8'd8;
    period("sw_cur8", 4, 4, 1'b1, 1, 8'd4);
    period("sw_next4_a", 2, 2, 1'b1, -1, 8'd0);
    period("sw_next4_b", 2, 2, 1'b1, -1, 8'd0);

    Divider = 8'd6;
    cyc("park_en", 4'b0101);
    Run = 1'b0;
    cyc("park_hi0", 4'b1001);
    cyc("park_hi1", 4'b1001);
    cyc("park_hi2", 4'b1011);
    cyc("park_lo0", 4'b0001);
    cyc("park_lo1", 4'b0001);
    cyc("park_lo2", 4'b0001);
    cyc("park_idle0", 4'b0000);
    cyc("park_idle1", 4'b0000);
    cyc("park_idle2", 4'b0000);

    Run     = 1'b1;
    Divider = 8'd8;
    cyc("pre_rst_en", 4'b0100);
    cyc("pre_rst_hi0", 4'b1001);
    Reset = 1'b1;
    cyc("rst_async", 4'b0000);
    cyc("rst_held", 4'b0000);
    Reset = 1'b0;
    period("restart_p0", 4, 4, 1'b0, -1, 8'd0);
    period("restart_p1", 4, 4, 1'b1, -1, 8'd0);
    cyc("restart_en", 4'b0101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
